// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants and FSM state type for the PS/2 set-2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Receiver pop handshake plus key-event bundle seen by the display stage.
interface ps2_scancode_decoder_if #(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 8
);
  logic              ready;
  logic [BYTE_W-1:0] data;
  logic              nextdata_n;
  logic              key_valid;
  logic [BYTE_W-1:0] key_code;
  logic [BYTE_W-1:0] key_ascii;
  logic              key_ext;
  logic              key_release;
  logic              key_repeat;
  logic              key_held;
  logic              shift;
  logic              caps;
  logic [CNT_W-1:0]  press_count;

  modport master (
    input  ready, data,
    output nextdata_n, key_valid, key_code, key_ascii, key_ext, key_release,
           key_repeat, key_held, shift, caps, press_count
  );

  modport slave (
    output ready, data,
    input  nextdata_n, key_valid, key_code, key_ascii, key_ext, key_release,
           key_repeat, key_held, shift, caps, press_count
  );
endinterface

// File: rtl/ps2_scancode_decoder_ascii.sv
// Set-2 scan code to ASCII ROM: letters, top-row digits/symbols and a few controls.
module scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  always_comb begin
    letter = 8'h00;
    ascii  = 8'h00;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
      8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
      8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
      8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
      8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
      8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
      8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      8'h45: ascii = shift ? ")" : "0";
      8'h16: ascii = shift ? "!" : "1";
      8'h1E: ascii = shift ? "@" : "2";
      8'h26: ascii = shift ? "#" : "3";
      8'h25: ascii = shift ? "$" : "4";
      8'h2E: ascii = shift ? "%" : "5";
      8'h36: ascii = shift ? "^" : "6";
      8'h3D: ascii = shift ? "&" : "7";
      8'h3E: ascii = shift ? "*" : "8";
      8'h46: ascii = shift ? "(" : "9";
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      8'h0D: ascii = 8'h09;
      default: ascii = 8'h00;
    endcase
    if (letter != 8'h00)
      ascii = upper ? (letter - 8'h20) : letter;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops scan-code bytes from the PS/2 receiver FIFO and turns them into key events.
// state  | meaning
// IDLE   | wait for ready, capture head byte, start pop strobe
// POP    | end pop strobe, decode captured byte, emit event
// SETTLE | let receiver ready/data catch up with the pop
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  clrn,
  ps2_scancode_decoder_if.master bus
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              ext_f, ext_d, brk_f, brk_d;
  logic [BYTE_W:0]   last_q, last_d;
  logic              held_q, held_d, shl_q, shl_d, shr_q, shr_d, caps_q, caps_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ndn_q, ndn_d, kv_q, kv_d;
  logic [BYTE_W-1:0] code_q, code_d, ascii_q, ascii_d;
  logic              kext_q, kext_d, krel_q, krel_d, krep_q, krep_d;
  logic [7:0]        rom_ascii;
  logic              shift_now;
  logic              repeat_hit;

  assign shift_now  = shl_q | shr_q;
  assign repeat_hit = held_q && (last_q == {ext_f, byte_q});

  scancode_to_ascii u_rom (
    .code  (byte_q),
    .shift (shift_now),
    .upper (shift_now ^ caps_q),
    .ascii (rom_ascii)
  );

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    ext_d   = ext_f;
    brk_d   = brk_f;
    last_d  = last_q;
    held_d  = held_q;
    shl_d   = shl_q;
    shr_d   = shr_q;
    caps_d  = caps_q;
    cnt_d   = cnt_q;
    ndn_d   = 1'b1;
    kv_d    = 1'b0;
    code_d  = code_q;
    ascii_d = ascii_q;
    kext_d  = kext_q;
    krel_d  = krel_q;
    krep_d  = krep_q;
    case (state_q)
      IDLE: begin
        if (bus.ready) begin
          byte_d  = bus.data;
          ndn_d   = 1'b0;
          state_d = POP;
        end
      end
      POP: begin
        state_d = SETTLE;
        if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_d = 1'b1;
        end else if (is_discard(byte_q)) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          kv_d    = 1'b1;
          code_d  = byte_q;
          ascii_d = ext_f ? '0 : rom_ascii;
          kext_d  = ext_f;
          krel_d  = brk_f;
          krep_d  = 1'b0;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          if (!brk_f) begin
            if (repeat_hit) begin
              krep_d = 1'b1;
            end else begin
              cnt_d  = cnt_q + 1'b1;
              last_d = {ext_f, byte_q};
              held_d = 1'b1;
              if (byte_q == SC_CAPS) caps_d = ~caps_q;
            end
            if (byte_q == SC_LSHIFT) shl_d = 1'b1;
            if (byte_q == SC_RSHIFT) shr_d = 1'b1;
          end else begin
            if (byte_q == SC_LSHIFT) shl_d = 1'b0;
            if (byte_q == SC_RSHIFT) shr_d = 1'b0;
            if (last_q == {ext_f, byte_q}) held_d = 1'b0;
          end
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      byte_q  <= '0;
      ext_f   <= 1'b0;
      brk_f   <= 1'b0;
      last_q  <= '0;
      held_q  <= 1'b0;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      caps_q  <= 1'b0;
      cnt_q   <= '0;
      ndn_q   <= 1'b1;
      kv_q    <= 1'b0;
      code_q  <= '0;
      ascii_q <= '0;
      kext_q  <= 1'b0;
      krel_q  <= 1'b0;
      krep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      ext_f   <= ext_d;
      brk_f   <= brk_d;
      last_q  <= last_d;
      held_q  <= held_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      caps_q  <= caps_d;
      cnt_q   <= cnt_d;
      ndn_q   <= ndn_d;
      kv_q    <= kv_d;
      code_q  <= code_d;
      ascii_q <= ascii_d;
      kext_q  <= kext_d;
      krel_q  <= krel_d;
      krep_q  <= krep_d;
    end
  end

  assign bus.nextdata_n  = ndn_q;
  assign bus.key_valid   = kv_q;
  assign bus.key_code    = code_q;
  assign bus.key_ascii   = ascii_q;
  assign bus.key_ext     = kext_q;
  assign bus.key_release = krel_q;
  assign bus.key_repeat  = krep_q;
  assign bus.key_held    = held_q;
  assign bus.shift       = shift_now;
  assign bus.caps        = caps_q;
  assign bus.press_count = cnt_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: FIFO model feeding bytes, event-level reference model.
module tb_ps2_scancode_decoder;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_scancode_decoder_if #(.BYTE_W(8), .CNT_W(8)) bus ();

  ps2_scancode_decoder #(.BYTE_W(8), .CNT_W(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Receiver FIFO model: pops when it sees nextdata_n low on a clock edge.
  logic [7:0]  fifo_mem [4096];
  logic [11:0] rd_ptr = '0;
  logic [11:0] wr_ptr = '0;
  assign bus.ready = (rd_ptr != wr_ptr);
  assign bus.data  = fifo_mem[rd_ptr];

  always @(posedge clk)
    if (clrn && !bus.nextdata_n && (rd_ptr != wr_ptr))
      rd_ptr <= rd_ptr + 12'd1;

  int compared   = 0;
  int mismatched = 0;
  int ev_cnt     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model of the decoder at the event level.
  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext, rel, rep, shift, caps, held;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  ev_t e_mon;

  bit m_ext, m_brk, m_held, m_shl, m_shr, m_caps;
  int m_last;
  int m_cnt;

  logic [7:0] lc_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dg_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string sym_str = ")!@#$%^&*(";

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit sh, input bit up);
    for (int i = 0; i < 26; i++)
      if (code == lc_tab[i]) return up ? 8'(65 + i) : 8'(97 + i);
    for (int d = 0; d < 10; d++)
      if (code == dg_tab[d]) return sh ? 8'(sym_str[d]) : 8'(48 + d);
    case (code)
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      8'h0D:   return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_shl = 0; m_shr = 0; m_caps = 0;
    m_last = -1;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    int key;
    bit sh;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      sh      = m_shl | m_shr;
      key     = (m_ext ? 256 : 0) + int'(b);
      e.code  = b;
      e.ext   = m_ext;
      e.rel   = m_brk;
      e.ascii = m_ext ? 8'h00 : ref_ascii(b, sh, sh ^ m_caps);
      e.rep   = 0;
      if (!m_brk) begin
        if (m_held && key == m_last) e.rep = 1;
        else begin
          m_cnt  = (m_cnt + 1) % 256;
          m_last = key;
          m_held = 1;
          if (b == 8'h58) m_caps = !m_caps;
        end
        if (b == 8'h12) m_shl = 1;
        if (b == 8'h59) m_shr = 1;
      end else begin
        if (b == 8'h12) m_shl = 0;
        if (b == 8'h59) m_shr = 0;
        if (key == m_last) m_held = 0;
      end
      e.shift = m_shl | m_shr;
      e.caps  = m_caps;
      e.held  = m_held;
      e.cnt   = 8'(m_cnt);
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 12'd1;
    model_byte(b);
  endtask

  task automatic drain();
    int n = 0;
    while (rd_ptr != wr_ptr && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(rd_ptr == wr_ptr), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (clrn && bus.key_valid) begin
      ev_cnt++;
      if (exp_q.size() == 0) chk("unexpected_event", 32'(exp_q.size()), 32'd1);
      else begin
        e_mon = exp_q.pop_front();
        chk("ev_code",    32'(bus.key_code),    32'(e_mon.code));
        chk("ev_ascii",   32'(bus.key_ascii),   32'(e_mon.ascii));
        chk("ev_ext",     32'(bus.key_ext),     32'(e_mon.ext));
        chk("ev_release", 32'(bus.key_release), 32'(e_mon.rel));
        chk("ev_repeat",  32'(bus.key_repeat),  32'(e_mon.rep));
        chk("ev_shift",   32'(bus.shift),       32'(e_mon.shift));
        chk("ev_caps",    32'(bus.caps),        32'(e_mon.caps));
        chk("ev_held",    32'(bus.key_held),    32'(e_mon.held));
        chk("ev_count",   32'(bus.press_count), 32'(e_mon.cnt));
      end
    end
  end

  logic [7:0] pool [20] = '{8'h12, 8'h59, 8'h58, 8'h1C, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h0D,
                            8'h75, 8'h1A, 8'h46, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'hFF, 8'h05};
  int ev0;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("rst_nextdata_n", 32'(bus.nextdata_n),  32'd1);
    chk("rst_key_valid",  32'(bus.key_valid),   32'd0);
    chk("rst_key_code",   32'(bus.key_code),    32'd0);
    chk("rst_flags",      32'({bus.key_ext, bus.key_release, bus.key_repeat, bus.key_held}), 32'd0);
    chk("rst_shift_caps", 32'({bus.shift, bus.caps}), 32'd0);
    chk("rst_count",      32'(bus.press_count), 32'd0);

    // Reset lands in the middle of POP; the byte stays in the FIFO and is re-read.
    fifo_mem[wr_ptr] = 8'h1C;
    wr_ptr = wr_ptr + 12'd1;
    @(negedge clk);
    chk("pop_strobe_low", 32'(bus.nextdata_n), 32'd0);
    clrn = 1'b0;
    #1;
    chk("rst_mid_pop_ndn", 32'(bus.nextdata_n), 32'd1);
    chk("rst_mid_pop_kv",  32'(bus.key_valid),  32'd0);
    model_reset();
    model_byte(8'h1C);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("t1_ndn_low",  32'(bus.nextdata_n), 32'd0);
    chk("t1_kv_low",   32'(bus.key_valid),  32'd0);
    @(negedge clk);
    chk("t2_ndn_high", 32'(bus.nextdata_n), 32'd1);
    chk("t2_kv_high",  32'(bus.key_valid),  32'd1);
    chk("t2_ascii",    32'(bus.key_ascii),  32'h61);
    chk("t2_count",    32'(bus.press_count), 32'd1);
    chk("t2_held",     32'(bus.key_held),   32'd1);
    @(negedge clk);
    chk("t3_kv_low",   32'(bus.key_valid),  32'd0);
    chk("t3_ndn_high", 32'(bus.nextdata_n), 32'd1);
    drain();

    // Shifted letter, then releases.
    do_reset();
    ev0 = ev_cnt;
    send(8'h12); send(8'h1C);
    drain();
    chk("shift_A_ascii", 32'(bus.key_ascii), 32'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    drain();
    chk("shift_seq_events", 32'(ev_cnt - ev0), 32'd4);
    chk("shift_seq_rel",    32'(bus.key_release), 32'd1);
    chk("shift_seq_shift",  32'(bus.shift), 32'd0);
    chk("shift_seq_held",   32'(bus.key_held), 32'd0);
    chk("shift_seq_count",  32'(bus.press_count), 32'd2);

    // Caps lock does not affect digits; shift does.
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h16);
    drain();
    chk("caps_on",      32'(bus.caps), 32'd1);
    chk("caps_digit",   32'(bus.key_ascii), 32'h31);
    send(8'h12); send(8'h16);
    drain();
    chk("shift_digit",  32'(bus.key_ascii), 32'h21);

    // Typematic repeat.
    do_reset();
    ev0 = ev_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C);
    drain();
    chk("rep_events", 32'(ev_cnt - ev0), 32'd3);
    chk("rep_flag",   32'(bus.key_repeat), 32'd1);
    chk("rep_count",  32'(bus.press_count), 32'd1);

    // Extended keys and discarded bytes.
    do_reset();
    send(8'hE0); send(8'h75);
    drain();
    chk("ext_flag",  32'(bus.key_ext), 32'd1);
    chk("ext_ascii", 32'(bus.key_ascii), 32'h00);
    chk("ext_held",  32'(bus.key_held), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    chk("ext_rel_held", 32'(bus.key_held), 32'd0);
    ev0 = ev_cnt;
    send(8'hAA);
    drain();
    chk("discard_no_event", 32'(ev_cnt - ev0), 32'd0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
    end
    drain();
    chk("count_wrap", 32'(bus.press_count), 32'd0);

    // Randomised byte stream with idle gaps.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom));
      else send(pool[$urandom_range(0, 19)]);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
